// File: rtl/avmm_init_pkg.sv
// Shared types for the Avalon-MM command initiator:
// FSM states, response status codes and the queued command bundle.
package avmm_init_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_e;

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_ERR = 2'b01;
   localparam logic [1:0] ST_TMO = 2'b10;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  byteen;
   } cmd_t;

endpackage

// File: rtl/avmm_cmd_fifo.sv
// Command FIFO: power-of-two depth, count-based full/empty.
// A push while full is dropped even if a pop happens the same cycle.
module avmm_cmd_fifo
   import avmm_init_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  cmd_t din,
   input  logic pop,
   output cmd_t dout,
   output logic full,
   output logic empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push_en, pop_en;
   cmd_t          mem_q [DEPTH];

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];

   // Next pointer and occupancy values
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_en);
      rd_ptr_d = rd_ptr_q + AW'(pop_en);
      cnt_d    = cnt_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
   end

   // Pointer and count registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/avmm_initiator_ctrl.sv
// Avalon-MM initiator: queues commands, runs them one at a time
// on the bus and returns one status/data response per command.
module avmm_initiator_ctrl
   import avmm_init_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_byteen,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_write,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_status,
   output logic        busy,
   output logic [31:0] avmm_addr,
   output logic [31:0] avmm_wdata,
   output logic [3:0]  avmm_byteen,
   output logic        avmm_read,
   output logic        avmm_write,
   input  logic        avmm_waitrq,
   input  logic        avmm_rdvalid,
   input  logic        avmm_wrvalid,
   input  logic [1:0]  avmm_response,
   input  logic [31:0] avmm_rdata
);

   // Counter value on the last permitted strobe cycle
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]  byteen_q, byteen_d;
   logic        read_q, read_d, write_q, write_d;
   logic        rsp_write_q, rsp_write_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]  rsp_status_q, rsp_status_d;

   cmd_t cmd_in, head;
   logic fifo_full, fifo_empty, fifo_pop, tmo;
   logic unused_wrvalid;

   assign unused_wrvalid = avmm_wrvalid;
   assign cmd_in = '{write:  cmd_write,
                     addr:   cmd_addr,
                     wdata:  cmd_wdata,
                     byteen: cmd_byteen};
   assign tmo = (cnt_q == TMO_LAST);

   avmm_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid),
      .din   (cmd_in),
      .pop   (fifo_pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state; completion wins over timeout
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (!fifo_empty) state_d = head.write ? WR : RD;
         RD:   if (avmm_rdvalid || tmo) state_d = RESP;
         WR:   if (!avmm_waitrq || tmo) state_d = RESP;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus strobes, timeout counter and response capture
   always_comb begin
      fifo_pop     = 1'b0;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      byteen_d     = byteen_q;
      read_d       = read_q;
      write_d      = write_q;
      rsp_write_d  = rsp_write_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_status_d = rsp_status_q;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               addr_d      = head.addr;
               wdata_d     = head.wdata;
               byteen_d    = head.byteen;
               read_d      = !head.write;
               write_d     = head.write;
               rsp_write_d = head.write;
               cnt_d       = '0;
            end
         end
         RD: begin
            cnt_d = cnt_q + 16'd1;
            if (avmm_rdvalid) begin
               read_d       = 1'b0;
               rsp_rdata_d  = avmm_rdata;
               rsp_status_d = ST_OK;
            end else if (tmo) begin
               read_d       = 1'b0;
               rsp_rdata_d  = '0;
               rsp_status_d = ST_TMO;
            end
         end
         WR: begin
            cnt_d = cnt_q + 16'd1;
            if (!avmm_waitrq) begin
               write_d      = 1'b0;
               rsp_rdata_d  = '0;
               rsp_status_d = (avmm_response == 2'b00) ? ST_OK : ST_ERR;
            end else if (tmo) begin
               write_d      = 1'b0;
               rsp_rdata_d  = '0;
               rsp_status_d = ST_TMO;
            end
         end
         RESP: ;
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         byteen_q     <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         rsp_write_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_status_q <= ST_OK;
      end else begin
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         byteen_q     <= byteen_d;
         read_q       <= read_d;
         write_q      <= write_d;
         rsp_write_q  <= rsp_write_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_status_q <= rsp_status_d;
      end
   end

   assign cmd_ready   = !fifo_full;
   assign busy        = !fifo_empty || (state_q != IDLE);
   assign rsp_valid   = (state_q == RESP);
   assign rsp_write   = rsp_write_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_status  = rsp_status_q;
   assign avmm_addr   = addr_q;
   assign avmm_wdata  = wdata_q;
   assign avmm_byteen = byteen_q;
   assign avmm_read   = read_q;
   assign avmm_write  = write_q;

endmodule

// File: tb/tb_avmm_initiator_ctrl.sv
// Directed bench for avmm_initiator_ctrl against a small
// memory-backed target with wait, error and hang modes.
module tb_avmm_initiator_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_byteen = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_status;
   logic        busy;
   logic [31:0] avmm_addr, avmm_wdata;
   logic [3:0]  avmm_byteen;
   logic        avmm_read, avmm_write;
   logic        avmm_waitrq, avmm_rdvalid, avmm_wrvalid;
   logic [1:0]  avmm_response;
   logic [31:0] avmm_rdata;

   int checks = 0;
   int passed = 0;

   logic        err_mode = 1'b0;
   logic        hang = 1'b0;
   logic        both_seen = 1'b0;
   logic [3:0]  age;
   logic [31:0] mem [16];

   avmm_initiator_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_byteen(cmd_byteen),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_status(rsp_status), .busy(busy),
      .avmm_addr(avmm_addr), .avmm_wdata(avmm_wdata),
      .avmm_byteen(avmm_byteen),
      .avmm_read(avmm_read), .avmm_write(avmm_write),
      .avmm_waitrq(avmm_waitrq), .avmm_rdvalid(avmm_rdvalid),
      .avmm_wrvalid(avmm_wrvalid), .avmm_response(avmm_response),
      .avmm_rdata(avmm_rdata)
   );

   always #5 clk = ~clk;

   // Target: answers one cycle after the strobe rises
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) age <= '0;
      else if (avmm_read || avmm_write) age <= (age == 4'hF) ? age : age + 4'd1;
      else age <= '0;
   end

   assign avmm_rdvalid  = avmm_read && (age >= 4'd1) && !hang;
   assign avmm_waitrq   = !(avmm_write && (age >= 4'd1));
   assign avmm_wrvalid  = avmm_write && !avmm_waitrq;
   assign avmm_response = err_mode ? 2'b01 : 2'b00;
   assign avmm_rdata    = avmm_rdvalid ? mem[avmm_addr[5:2]] : 32'h0;

   always @(posedge clk) begin
      if (avmm_write && !avmm_waitrq) mem[avmm_addr[5:2]] <= avmm_wdata;
   end

   always @(negedge clk) begin
      if (avmm_read && avmm_write) both_seen = 1'b1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a;
      cmd_wdata = d; cmd_byteen = be;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int max);
      int n = 0;
      while (rsp_valid !== 1'b1 && n < max) begin
         step();
         n++;
      end
      check("rsp_arrives", {31'd0, rsp_valid}, 32'd1);
   endtask

   logic        bw [5];
   logic [31:0] ba [5];
   logic [31:0] bd [5];
   logic [31:0] be_rd [5];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ncyc;
      logic seen;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      bw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      ba = '{32'h10, 32'h10, 32'h14, 32'h14, 32'h8};
      bd = '{32'hA1, 32'h0, 32'hB2, 32'h0, 32'h0};
      be_rd = '{32'h0, 32'hA1, 32'h0, 32'hB2, 32'hDEADBEEF};

      // Reset values
      step(); step();
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_strobes", {30'd0, avmm_read, avmm_write}, 32'd0);
      check("rst_addr", avmm_addr, 32'd0);
      check("rst_rsp", {rsp_write, rsp_status, rsp_rdata[28:0]}, 32'd0);
      rst_n = 1'b1;
      step();

      // Write 0x8 <- DEADBEEF, 4-cycle latency
      issue(1'b1, 32'h8, 32'hDEADBEEF, 4'hF);
      step();
      check("wr_strobe", {31'd0, avmm_write}, 32'd1);
      check("wr_addr", avmm_addr, 32'h8);
      check("wr_wdata", avmm_wdata, 32'hDEADBEEF);
      step();
      check("wr_lat_c3", {31'd0, rsp_valid}, 32'd0);
      step();
      check("wr_lat_c4", {31'd0, rsp_valid}, 32'd1);
      check("wr_rsp_write", {31'd0, rsp_write}, 32'd1);
      check("wr_rsp_status", {30'd0, rsp_status}, 32'd0);
      step();
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Read back 0x8
      issue(1'b0, 32'h8, 32'h0, 4'hF);
      step();
      check("rd_strobe", {31'd0, avmm_read}, 32'd1);
      step();
      check("rd_lat_c3", {31'd0, rsp_valid}, 32'd0);
      step();
      check("rd_lat_c4", {31'd0, rsp_valid}, 32'd1);
      check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
      check("rd_status", {30'd0, rsp_status}, 32'd0);
      check("rd_rsp_write", {31'd0, rsp_write}, 32'd0);
      step();

      // Target error on write
      err_mode = 1'b1;
      issue(1'b1, 32'h100, 32'h1234, 4'hF);
      wait_rsp(10);
      check("err_status", {30'd0, rsp_status}, 32'd1);
      check("err_write", {31'd0, rsp_write}, 32'd1);
      step();
      err_mode = 1'b0;

      // Byte enables held through the strobe
      issue(1'b1, 32'hC, 32'h55AA, 4'b0011);
      step();
      check("be_c2", {27'd0, avmm_write, avmm_byteen}, 32'h13);
      step();
      check("be_c3", {27'd0, avmm_write, avmm_byteen}, 32'h13);
      wait_rsp(10);
      step();

      // Timeout on a read that never returns data
      hang = 1'b1;
      issue(1'b0, 32'h8, 32'h0, 4'hF);
      ncyc = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (avmm_read) ncyc++;
         if (rsp_valid) break;
      end
      check("tmo_strobe_len", ncyc, 32'd8);
      check("tmo_valid", {31'd0, rsp_valid}, 32'd1);
      check("tmo_status", {30'd0, rsp_status}, 32'd2);
      check("tmo_rdata", rsp_rdata, 32'd0);
      step();
      hang = 1'b0;
      issue(1'b0, 32'h8, 32'h0, 4'hF);
      wait_rsp(10);
      check("post_tmo_rdata", rsp_rdata, 32'hDEADBEEF);
      check("post_tmo_status", {30'd0, rsp_status}, 32'd0);
      step();

      // Backpressure: fill the FIFO while responses stall
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1; cmd_write = bw[i]; cmd_addr = ba[i];
         cmd_wdata = bd[i]; cmd_byteen = 4'hF;
         step();
         if (i == 3) check("bp_ready_4", {31'd0, cmd_ready}, 32'd1);
         if (i == 4) check("bp_ready_5", {31'd0, cmd_ready}, 32'd0);
      end
      cmd_write = 1'b1; cmd_addr = 32'h18; cmd_wdata = 32'hFF;
      step();
      check("bp_blocked", {31'd0, cmd_ready}, 32'd0);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_rsp(30);
         check("bp_write", {31'd0, rsp_write}, {31'd0, bw[k]});
         check("bp_rdata", rsp_rdata, be_rd[k]);
         check("bp_status", {30'd0, rsp_status}, 32'd0);
         step();
         if (k == 0) begin
            step();
            check("bp_ready_back", {31'd0, cmd_ready}, 32'd1);
         end
      end
      step(); step();
      check("bp_idle", {31'd0, busy}, 32'd0);

      // Reset in the middle of a read with two queued
      hang = 1'b1;
      issue(1'b0, 32'h8, 32'h0, 4'hF);
      issue(1'b0, 32'h10, 32'h0, 4'hF);
      issue(1'b0, 32'h14, 32'h0, 4'hF);
      check("mid_read", {30'd0, avmm_read, busy}, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("ar_strobe", {30'd0, avmm_read, avmm_write}, 32'd0);
      check("ar_busy", {31'd0, busy}, 32'd0);
      check("ar_ready", {31'd0, cmd_ready}, 32'd1);
      check("ar_addr", avmm_addr, 32'd0);
      check("ar_rsp", {rsp_valid, rsp_status, rsp_rdata[28:0]}, 32'd0);
      step(); step();
      rst_n = 1'b1;
      hang = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         seen = seen | rsp_valid | busy;
      end
      check("ar_quiet", {31'd0, seen}, 32'd0);

      check("never_both", {31'd0, both_seen}, 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
